imem_loader: RTL
================

# imem_loader

Boot-time program loader for the 8-bit accumulator CPU: writer side of the instruction-memory read port the CPU fetches through (`pc_imem` → `ir_imem`). Accepts a framed byte stream over a valid/ready handshake, writes payload bytes into instruction memory from `BASE_ADDR` upward, and holds the CPU in reset until a frame with a good checksum has been loaded. Sits between the host/byte source and the imem write port; its `cpu_hold` output drives the CPU's `reset`.

## Interface
- `HEADER`, 8'hA5, frame start byte
- `BASE_ADDR`, 8'h00, imem address of first payload byte
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high; returns block to IDLE
- `in_data`  input  8  stream byte
- `in_valid`  input  1  `in_data` valid
- `in_ready`  output  1  loader can accept; byte transfers when `in_valid && in_ready` on a rising edge
- `wm_imem`  output  1  imem write enable, one-cycle pulse per payload byte
- `waddr_imem`  output  8  imem write address
- `wdata_imem`  output  8  imem write data
- `cpu_hold`  output  1  CPU reset request; high until successful load
- `done`  output  1  load completed, checksum good (level)
- `err`  output  1  checksum mismatch on last frame (level)

## Operation
- Frame: `HEADER`, LEN, LEN payload bytes, CHK. LEN = 0 encodes 256 bytes. CHK = 8-bit sum (mod 256) of payload bytes.
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE: `in_ready`=1; byte == `HEADER` → LEN; any other byte discarded.
- LEN: accept byte, load 9-bit remaining counter (0 → 256), clear checksum, set write pointer to `BASE_ADDR` → DATA.
- DATA: each accepted byte written to imem at pointer, added to checksum, pointer +1 (8-bit wrap: 256-byte frame with nonzero `BASE_ADDR` wraps to 0), counter −1; counter reaching 0 → CHK.
- CHK: accepted byte == running sum → DONE, else → ERR.
- DONE: `in_ready`=0, `cpu_hold`=0, `done`=1; remains until `reset`.
- ERR: `in_ready`=1, `cpu_hold`=1, `err`=1; byte == `HEADER` → LEN (clears `err`); other bytes discarded. Imem contents from the bad frame are left in place; they are never executed because the CPU stays held.
- No bytes are accepted in DONE; the block never writes imem outside DATA.

## Timing
- Reset values: state IDLE, `in_ready`=1, `wm_imem`=0, `waddr_imem`=8'h00, `wdata_imem`=8'h00, `cpu_hold`=1, `done`=0, `err`=0.
- `in_ready` is a function of state only (registered state, no combinational path from `in_valid`).
- Write latency: payload byte accepted at edge k → `wm_imem`/`waddr_imem`/`wdata_imem` valid during the cycle after edge k, sampled by imem at edge k+1. Back-to-back bytes give back-to-back write pulses.
- `cpu_hold` falls and `done` rises in the cycle after the edge that accepts a good CHK; the last payload write has committed at or before that edge.
- `in_valid` gaps: state and counters hold; `wm_imem` is 0 in every cycle not following a payload acceptance.
- `reset` mid-frame: abandons frame, reasserts `cpu_hold`, clears `done`/`err` at next edge; partially written imem is not cleared.

## Structure
- Shared CPU package: `HEADER` default, loader state encoding, 8-bit data/address width constants (same widths as the CPU's pc/ir buses).
- Single module; no sub-module needed (checksum is one adder, counter and pointer are inline registers).

## Test plan
- Nominal: reset, stream A5 03 11 22 33 66 with `in_valid` held → three write pulses (00:11, 01:22, 02:33), then `done`=1, `cpu_hold`=0, `in_ready`=0.
- Bad checksum: A5 02 10 20 31 → writes 00:10, 01:20, then `err`=1, `cpu_hold`=1; follow with A5 01 7F 7F → `done`=1, `err`=0.
- Noise and stalls: 00 FF A5 02 01 02 03 with random `in_valid` gaps → leading 00/FF ignored, exactly two write pulses, `done`=1.
- LEN=0: A5 00 then 256 bytes of 01 then CHK 00 → 256 writes addresses 00..FF, `done`=1.
- Reset mid-frame: A5 04 AA BB then `reset` one cycle → `cpu_hold`=1, state IDLE, next A5 01 05 05 loads 00:05 and `done`=1.
- `BASE_ADDR`=8'hFE, frame A5 03 01 02 03 06 → writes FE:01, FF:02, 00:03.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared CPU-side definitions for the instruction-memory loader.
// Data and address widths match the CPU pc/ir buses.
package imem_loader_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [DATA_W-1:0] HEADER_DEF    = 8'hA5;
    localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ld_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> imem writes, holds CPU until checksum-good load.
// Latency: payload byte accepted at edge k drives the imem write port during cycle k..k+1.
// Backpressure: in_ready depends on state only; low solely once the load is done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [DATA_W-1:0] HEADER    = HEADER_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wm_imem,
    output logic [ADDR_W-1:0] waddr_imem,
    output logic [DATA_W-1:0] wdata_imem,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    ld_state_t         r_state;
    logic [8:0]        r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_sum;
    logic              r_in_ready;
    logic              r_wm;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;

    logic w_acc;
    assign w_acc = in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b1;
            r_wm       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wm <= 1'b0;
            if (w_acc) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (in_data == HEADER) r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        // A zero length byte encodes a full 256-byte frame.
                        r_cnt   <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        r_sum   <= '0;
                        r_ptr   <= BASE_ADDR;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_wm    <= 1'b1;
                        r_waddr <= r_ptr;
                        r_wdata <= in_data;
                        r_sum   <= r_sum + in_data;
                        r_ptr   <= r_ptr + 8'd1;
                        r_cnt   <= r_cnt - 9'd1;
                        if (r_cnt == 9'd1) r_state <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (in_data == r_sum) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        // Bad-frame bytes stay in imem; the CPU remains held.
                        if (in_data == HEADER) begin
                            r_state <= ST_LEN;
                            r_err   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign wm_imem    = r_wm;
    assign waddr_imem = r_waddr;
    assign wdata_imem = r_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;

endmodule
